pattern_sequencer: RTL

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/kros_pkg.sv | 29 ++
 rtl/pattern_sequencer_if.sv | 17 +
 rtl/edge_detect.sv | 34 +++
 rtl/pattern_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/kros_pkg.sv
// ---------------------------------------------------------------------------
// kros_pkg
// Shared widths and FSM state type for the LED pattern sequencer.
//   SEQ_W  : sequence index width (16 sequences)
//   STEP_W : step index width (64 words per sequence, word 0 holds the length)
//   PAT_W  : LED pattern / ROM data width
//   ADDR_W : pattern ROM address width, {seq, step}
// ---------------------------------------------------------------------------
package kros_pkg;

    localparam int SEQ_W  = 4;
    localparam int STEP_W = 6;
    localparam int PAT_W  = 10;
    localparam int ADDR_W = SEQ_W + STEP_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LEN_WAIT   = 2'd1,
        WAIT_TICK  = 2'd2,
        FETCH_WAIT = 2'd3
    } state_e;

    // ROM word address of a given step inside a given sequence.
    function automatic logic [ADDR_W-1:0] rom_word(input logic [SEQ_W-1:0]  seq,
                                                   input logic [STEP_W-1:0] step);
        return {seq, step};
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// pattern_sequencer_if
// Read port of the external pattern ROM.
//   rom_addr : registered word address, {seq_num, step}
//   rom_q    : read data, valid ROM_LAT clocks after rom_addr changes
// Modports: master = sequencer (drives the address), slave = ROM.
// ---------------------------------------------------------------------------
interface pattern_sequencer_if;
    import kros_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [PAT_W-1:0]  rom_q;

    modport master (output rom_addr, input  rom_q);
    modport slave  (input  rom_addr, output rom_q);

endinterface

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for an already debounced, synchronous level.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_level : input level
//   o_rise  : high for the one cycle in which i_level is seen going 0 -> 1
// ---------------------------------------------------------------------------
module edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // r_armed stays low for the first clock after reset release so that a
    // level which is already high at release is absorbed into r_prev
    // instead of being reported as a fresh press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
// Plays LED patterns stored in an external ROM. Each sequence owns 64 words:
// word 0 holds the length L in bits [5:0], words 1..L hold the patterns.
// Each step_tick fetches the next pattern and shows it on led_out, wrapping
// from step L back to step 1.
//
// Parameter:
//   ROM_LAT      : ROM read latency in clocks, 1..3
// Ports:
//   CLK_50       : 50 MHz clock
//   reset        : asynchronous active-low reset
//   run          : 1 = play, 0 = pause (return to IDLE)
//   step_tick    : one-cycle advance pulse
//   seq_up       : debounced level, rising edge selects next sequence
//   seq_dn       : debounced level, rising edge selects previous sequence
//   rom          : ROM read port (rom_addr out, rom_q in)
//   led_out      : registered LED pattern
//   seq_num      : current sequence index
//   step_num     : step currently displayed, 0 when nothing shown
//   tick_overrun : one-cycle pulse when a step_tick is dropped
// ---------------------------------------------------------------------------
module pattern_sequencer
    import kros_pkg::*;
#(
    parameter int ROM_LAT = 2
) (
    input  logic                 CLK_50,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step_tick,
    input  logic                 seq_up,
    input  logic                 seq_dn,
    pattern_sequencer_if.master  rom,
    output logic [PAT_W-1:0]     led_out,
    output logic [SEQ_W-1:0]     seq_num,
    output logic [STEP_W-1:0]    step_num,
    output logic                 tick_overrun
);

    localparam logic [1:0]        LAT_LAST   = 2'(ROM_LAT);
    localparam logic [STEP_W-1:0] STEP_FIRST = STEP_W'(1);

    state_e              r_state;
    logic [1:0]          r_cnt;
    logic [STEP_W-1:0]   r_len;
    logic [STEP_W-1:0]   r_step;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [PAT_W-1:0]    r_led;
    logic [SEQ_W-1:0]    r_seq;
    logic [STEP_W-1:0]   r_step_num;
    logic                r_overrun;

    state_e              w_state_nxt;
    logic [1:0]          w_cnt_nxt;
    logic [STEP_W-1:0]   w_len_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [ADDR_W-1:0]   w_rom_addr_nxt;
    logic [PAT_W-1:0]    w_led_nxt;
    logic [SEQ_W-1:0]    w_seq_nxt;
    logic [STEP_W-1:0]   w_step_num_nxt;
    logic                w_overrun_nxt;

    logic                w_up_rise;
    logic                w_dn_rise;
    logic                w_seq_chg;
    logic                w_cnt_done;
    logic [STEP_W-1:0]   w_rom_len;

    edge_detect u_up_edge (
        .i_clk   (CLK_50),
        .i_rst_n (reset),
        .i_level (seq_up),
        .o_rise  (w_up_rise)
    );

    edge_detect u_dn_edge (
        .i_clk   (CLK_50),
        .i_rst_n (reset),
        .i_level (seq_dn),
        .o_rise  (w_dn_rise)
    );

    // Simultaneous up and down presses cancel each other.
    assign w_seq_chg  = w_up_rise ^ w_dn_rise;
    assign w_cnt_done = (r_cnt == LAT_LAST);
    assign w_rom_len  = rom.rom_q[STEP_W-1:0];

    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_step     <= STEP_FIRST;
            r_rom_addr <= '0;
            r_led      <= '0;
            r_seq      <= '0;
            r_step_num <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len      <= w_len_nxt;
            r_step     <= w_step_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_led      <= w_led_nxt;
            r_seq      <= w_seq_nxt;
            r_step_num <= w_step_num_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_nxt      = r_len;
        w_step_nxt     = r_step;
        w_rom_addr_nxt = r_rom_addr;
        w_led_nxt      = r_led;
        w_seq_nxt      = r_seq;
        w_step_num_nxt = r_step_num;
        w_overrun_nxt  = 1'b0;

        // The sequence index follows the buttons in every state, paused or not.
        if (w_seq_chg) begin
            w_seq_nxt = w_up_rise ? (r_seq + 1'b1) : (r_seq - 1'b1);
        end

        if (!run) begin
            // Pause: any read in flight is simply abandoned; outputs hold.
            w_state_nxt = IDLE;
        end else if (w_seq_chg && (r_state != IDLE)) begin
            // Restart on the new sequence; a tick in this cycle is dropped
            // silently because the selection change takes precedence.
            w_rom_addr_nxt = rom_word(w_seq_nxt, '0);
            w_cnt_nxt      = 2'd1;
            w_state_nxt    = LEN_WAIT;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_seq_chg) begin
                        w_rom_addr_nxt = rom_word(r_seq, '0);
                        w_cnt_nxt      = 2'd1;
                        w_state_nxt    = LEN_WAIT;
                    end
                end
                LEN_WAIT: begin
                    w_overrun_nxt = step_tick;
                    if (w_cnt_done) begin
                        w_len_nxt   = w_rom_len;
                        w_step_nxt  = STEP_FIRST;
                        w_state_nxt = WAIT_TICK;
                        // An empty sequence blanks the display immediately.
                        if (w_rom_len == '0) begin
                            w_led_nxt      = '0;
                            w_step_num_nxt = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (step_tick && (r_len != '0)) begin
                        w_rom_addr_nxt = rom_word(r_seq, r_step);
                        w_cnt_nxt      = 2'd1;
                        w_state_nxt    = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    w_overrun_nxt = step_tick;
                    if (w_cnt_done) begin
                        w_led_nxt      = rom.rom_q;
                        w_step_num_nxt = r_step;
                        w_step_nxt     = (r_step == r_len) ? STEP_FIRST : (r_step + 1'b1);
                        w_state_nxt    = WAIT_TICK;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign rom.rom_addr = r_rom_addr;
    assign led_out      = r_led;
    assign seq_num      = r_seq;
    assign step_num     = r_step_num;
    assign tick_overrun = r_overrun;

endmodule
